// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: shared operation codes and timing defaults for the MIPS
// multiply/divide unit.
//   mdu_op_e         - 4-bit MDUOp encoding driven by the decoder
//   MULT_CYCLES_DEF  - default Busy length for mult/multu
//   DIV_CYCLES_DEF   - default Busy length for div/divu
package mdu_hilo_pkg;

    typedef enum logic [3:0] {
        mdu_none  = 4'd0,
        mdu_mult  = 4'd1,
        mdu_multu = 4'd2,
        mdu_div   = 4'd3,
        mdu_divu  = 4'd4,
        mdu_mthi  = 4'd5,
        mdu_mtlo  = 4'd6,
        mdu_mfhi  = 4'd7,
        mdu_mflo  = 4'd8
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit with architectural HI/LO registers.
// The full 64-bit product or quotient/remainder is computed in the cycle an
// op is accepted and parked in pending registers; a down-counter holds Busy
// for the configured latency and then commits the pending values.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous, active-low
//   Start   - EX-stage instruction is an MDU op
//   MDUOp   - operation code (mdu_op_e)
//   SrcA    - rs operand (forwarded)
//   SrcB    - rt operand (forwarded)
//   Cancel  - EX instruction is flushed; suppresses Start this cycle
//   Busy    - multi-cycle op in progress (registered)
//   HI, LO  - architectural HI/LO
//   Result  - HI for mfhi, LO for mflo, otherwise 0 (combinational)
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Result
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Signed divide returning {remainder, quotient}. The INT_MIN / -1 case
    // is pinned explicitly so no overflowing divide is ever evaluated.
    function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] as_v;
        logic signed [31:0] bs_v;
        as_v = a;
        bs_v = b;
        if (b == 32'h0)
            return 64'h0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'h0, 32'h8000_0000};
        return {32'(as_v % bs_v), 32'(as_v / bs_v)};
    endfunction

    mdu_op_e op;
    assign op = mdu_op_e'(MDUOp);

    logic               accept;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] div_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    logic               is_long;
    logic               nxt_commit;
    logic [CNT_W-1:0]   nxt_cnt;
    logic        [31:0] nxt_hi;
    logic        [31:0] nxt_lo;
    logic               wr_hi;
    logic               wr_lo;

    logic        [31:0] hi_q;
    logic        [31:0] lo_q;
    logic        [31:0] hi_pend_p0;
    logic        [31:0] lo_pend_p0;
    logic               commit_p0;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;

    assign accept = Start & ~Cancel & ~busy_q;

    assign prod_s = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
    assign prod_u = {32'h0, SrcA} * {32'h0, SrcB};
    assign div_s  = sdiv(SrcA, SrcB);
    assign quot_u = (SrcB == 32'h0) ? 32'h0 : SrcA / SrcB;
    assign rem_u  = (SrcB == 32'h0) ? 32'h0 : SrcA % SrcB;

    always_comb begin
        is_long    = 1'b0;
        nxt_commit = 1'b0;
        nxt_cnt    = '0;
        nxt_hi     = hi_q;
        nxt_lo     = lo_q;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (op)
            mdu_mult: begin
                is_long    = 1'b1;
                nxt_commit = 1'b1;
                nxt_cnt    = CNT_W'(MULT_CYCLES - 1);
                {nxt_hi, nxt_lo} = prod_s;
            end
            mdu_multu: begin
                is_long    = 1'b1;
                nxt_commit = 1'b1;
                nxt_cnt    = CNT_W'(MULT_CYCLES - 1);
                {nxt_hi, nxt_lo} = prod_u;
            end
            mdu_div: begin
                is_long    = 1'b1;
                // Divide by zero still occupies the unit but never commits.
                nxt_commit = (SrcB != 32'h0);
                nxt_cnt    = CNT_W'(DIV_CYCLES - 1);
                {nxt_hi, nxt_lo} = div_s;
            end
            mdu_divu: begin
                is_long    = 1'b1;
                nxt_commit = (SrcB != 32'h0);
                nxt_cnt    = CNT_W'(DIV_CYCLES - 1);
                nxt_hi     = rem_u;
                nxt_lo     = quot_u;
            end
            mdu_mthi: wr_hi = 1'b1;
            mdu_mtlo: wr_lo = 1'b1;
            default: ;
        endcase
    end

    // Stage p0: operands resolved into pending HI/LO at acceptance; the
    // counter releases them into the architectural registers when it expires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q       <= 32'h0;
            lo_q       <= 32'h0;
            hi_pend_p0 <= 32'h0;
            lo_pend_p0 <= 32'h0;
            commit_p0  <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
                if (commit_p0) begin
                    hi_q <= hi_pend_p0;
                    lo_q <= lo_pend_p0;
                end
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end else if (accept) begin
            if (is_long) begin
                hi_pend_p0 <= nxt_hi;
                lo_pend_p0 <= nxt_lo;
                commit_p0  <= nxt_commit;
                cnt_q      <= nxt_cnt;
                busy_q     <= 1'b1;
            end
            if (wr_hi) hi_q <= SrcA;
            if (wr_lo) lo_q <= SrcA;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        Result = 32'h0;
        if (op == mdu_mfhi) Result = hi_q;
        else if (op == mdu_mflo) Result = lo_q;
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed and randomized bench for mdu_hilo with a plain
// arithmetic reference model of HI/LO and the expected Busy length.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Cancel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Result;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
        .SrcA(SrcA), .SrcB(SrcB), .Cancel(Cancel),
        .Busy(Busy), .HI(HI), .LO(LO), .Result(Result)
    );

    always #5 clk = ~clk;

    // The hazard unit must never present Start while Busy.
    always @(posedge clk) begin
        if (reset === 1'b1 && Start === 1'b1 && Busy === 1'b1) begin
            n_total++;
            assert (1'b0) else $error("FAIL start_while_busy: Start=%b Busy=%b required no overlap", Start, Busy);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one op for a single cycle, track Busy, and compare HI/LO/Result
    // with the reference model.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic        [63:0] ua, ub, up;
        logic        [31:0] nh, nl, old_hi;
        int len, cnt;
        nh = exp_hi;
        nl = exp_lo;
        len = 0;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (!c) begin
            case (op)
                mdu_mult:  begin sp = sa * sb; nh = sp[63:32]; nl = sp[31:0]; len = MC; end
                mdu_multu: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; len = MC; end
                mdu_div: begin
                    len = DC;
                    if (b != 0) begin sq = sa / sb; sr = sa % sb; nh = sr[31:0]; nl = sq[31:0]; end
                end
                mdu_divu: begin
                    len = DC;
                    if (b != 0) begin nh = 32'(ua % ub); nl = 32'(ua / ub); end
                end
                mdu_mthi: nh = a;
                mdu_mtlo: nl = a;
                default: ;
            endcase
        end
        old_hi = exp_hi;
        @(negedge clk);
        Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b; Cancel = c;
        @(negedge clk);
        Start = 1'b0; Cancel = 1'b0; MDUOp = mdu_mfhi;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 40) begin
            #1 check("rd_hi_while_busy", Result, old_hi);
            cnt++;
            @(negedge clk);
        end
        exp_hi = nh;
        exp_lo = nl;
        check("busy_len", 32'(cnt), 32'(len));
        check("hi", HI, exp_hi);
        check("lo", LO, exp_lo);
        #1 check("mfhi", Result, exp_hi);
        MDUOp = mdu_mflo;
        #1 check("mflo", Result, exp_lo);
        MDUOp = mdu_none;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] ops [10];

    initial begin
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd9, 4'd13, 4'd15};
        reset = 1'b0; Start = 1'b0; MDUOp = mdu_none; SrcA = '0; SrcB = '0; Cancel = 1'b0;
        exp_hi = 32'h0; exp_lo = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("rst_busy", {31'h0, Busy}, 32'h0);
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);

        // Directed cases.
        do_op(mdu_mult,  32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_hi_val", HI, 32'hFFFF_FFFF);
        check("mult_lo_val", LO, 32'hFFFF_FFFA);
        do_op(mdu_multu, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("multu_hi_val", HI, 32'h0000_0002);
        do_op(mdu_div,   32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo_val", LO, 32'hFFFF_FFFD);
        check("div_hi_val", HI, 32'hFFFF_FFFF);
        do_op(mdu_mthi,  32'h1234, 32'h0, 1'b0);
        do_op(mdu_mtlo,  32'h5678, 32'h0, 1'b0);
        do_op(mdu_divu,  32'hDEAD_BEEF, 32'h0, 1'b0);
        check("div0_hi", HI, 32'h1234);
        check("div0_lo", LO, 32'h5678);
        do_op(mdu_div,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'h0);
        do_op(mdu_mult,  32'h1111_1111, 32'h2222_2222, 1'b1);
        check("cancel_lo", LO, 32'h8000_0000);
        do_op(mdu_mtlo,  32'hABCD, 32'h0, 1'b0);
        check("mtlo_val", LO, 32'hABCD);
        do_op(4'd12,     32'h5555_5555, 32'h3, 1'b0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++)
            do_op(ops[$urandom_range(0, 9)], pick(), pick(), ($urandom_range(0, 7) == 0));

        // Reset in the middle of a divide aborts it.
        @(negedge clk);
        Start = 1'b1; MDUOp = mdu_div; SrcA = 32'd100; SrcB = 32'd7; Cancel = 1'b0;
        @(negedge clk);
        Start = 1'b0; MDUOp = mdu_none;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'h0, Busy}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_hi = 32'h0; exp_lo = 32'h0;
        check("midrst_busy", {31'h0, Busy}, 32'h0);
        check("midrst_hi", HI, exp_hi);
        check("midrst_lo", LO, exp_lo);
        repeat (12) @(negedge clk);
        check("no_late_hi", HI, exp_hi);
        check("no_late_lo", LO, exp_lo);
        check("no_late_busy", {31'h0, Busy}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
